keyboard_move_decoder: RTL and testbench
========================================

KEYBOARD_MOVE_DECODER -- requirements
Module: keyboard_move_decoder

Interface
REQ-001 SHALL have parameter MOVE_COOLDOWN, default 25000000: minimum clock cycles between successive move pulses.
REQ-002 SHALL have parameter CNT_W, default 25: width of the cooldown counter; MOVE_COOLDOWN SHALL fit in CNT_W bits.
REQ-003 SHALL have port clock  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port received_data  input  8  scan-code byte from the PS/2 controller.
REQ-006 SHALL have port received_data_en  input  1  one-cycle strobe; received_data is valid in that cycle.
REQ-007 SHALL have port move  output  1  one-cycle move request to the game FSM.
REQ-008 SHALL have port dir  output  3  direction of the latest move: 111 top-left, 101 bottom-left, 100 bottom-right, 110 top-right.
REQ-009 SHALL have port activate  output  1  one-cycle activate request (space key).
REQ-010 SHALL have port key_held  output  1  high while a registered direction key is held.

Function
REQ-011 SHALL run a byte-sequence FSM with states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen), advancing only on cycles where received_data_en=1.
REQ-012 IDLE transitions: E0 -> EXT; F0 -> BRK; any other byte is treated as a make code and the FSM stays in IDLE.
REQ-013 EXT transitions: F0 -> EXT_BRK; any other byte is treated as an extended make code -> IDLE.
REQ-014 BRK and EXT_BRK SHALL treat the next byte as a break code -> IDLE.
REQ-015 Make-code map: 1D -> 111, 1C -> 101, 1B -> 100, 23 -> 110; 29 -> activate; all other codes are ignored.
REQ-016 On a mapped direction make code with cooldown=0 and the code not equal to the held code: assert move for exactly one cycle in the cycle after the strobe, update dir in that same cycle, record the code as held, and load cooldown with MOVE_COOLDOWN.
REQ-017 A make code equal to the held code (typematic repeat) SHALL be ignored.
REQ-018 A direction make code arriving while cooldown!=0 SHALL be dropped, leaving the held code, dir and cooldown unchanged.
REQ-019 A different mapped direction make code arriving while a key is held and cooldown=0 SHALL produce a move and replace the held code.
REQ-020 A break code equal to the held code SHALL clear the held code; any other break code SHALL be ignored.
REQ-021 Make code 29 SHALL pulse activate for one cycle in the cycle after the strobe; activate is independent of cooldown; the break code for 29 is ignored.
REQ-022 Cooldown SHALL decrement by 1 per cycle while nonzero and saturate at 0; a load SHALL take priority over a decrement in the same cycle.
REQ-023 dir SHALL hold its value between moves; move and activate SHALL never be high for more than one consecutive cycle.
REQ-024 key_held SHALL be high exactly when a held code is recorded.

Reset
REQ-025 While resetn=0 at a clock edge: FSM -> IDLE, move=0, activate=0, dir=000, held code cleared, key_held=0, cooldown=0.
REQ-026 Reset mid-sequence (e.g. after E0 or F0) SHALL discard the partial sequence; the first byte after reset is decoded starting from IDLE.

Configuration
REQ-027 When macro KBD_ARROW_KEYS_EN is defined, extended make codes 75 -> 111, 6B -> 101, 72 -> 100, 74 -> 110 SHALL act as direction keys, and the matching extended break codes SHALL clear them as held keys.
REQ-028 When KBD_ARROW_KEYS_EN is not defined, extended sequences SHALL still be parsed (EXT and EXT_BRK states are retained) but SHALL produce no output and no held-state change.

Structure
REQ-029 Shared package kbd_pkg SHALL hold the scan-code constants (E0, F0, 1D, 1C, 1B, 23, 29, 75, 6B, 72, 74), the 3-bit direction encodings, and the FSM state encoding.
REQ-030 The cooldown counter SHALL be a sub-module named move_cooldown_timer with inputs load and clear and output busy.

Verification
REQ-031 Test 1: after reset, strobe 1D -> move=1 for one cycle exactly 1 cycle after the strobe, dir=111, key_held=1.
REQ-032 Test 2: with MOVE_COOLDOWN=8, strobe 1D, then 1D repeated every 2 cycles -> exactly one move; then strobe F0 1D -> key_held=0.
REQ-033 Test 3: with MOVE_COOLDOWN=8, strobe 1C then 23 three cycles later -> 23 dropped, dir stays 101; after 8 cycles strobe 23 -> move=1 with dir=110.
REQ-034 Test 4: strobe 29 -> activate one-cycle pulse, move=0; strobe F0 29 -> no output.
REQ-035 Test 5: with KBD_ARROW_KEYS_EN defined, strobe E0 72 -> move=1 with dir=100; with it undefined, the same stimulus gives move=0 and a following 1B gives move=1 with dir=100.
REQ-036 Test 6: strobe E0, assert resetn=0 for one cycle, then strobe 1B -> move=1 with dir=100, with no stale extended decoding.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan-code constants, direction encodings and parser state encoding
// for the PS/2 move decoder.
package kbd_pkg;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_TL        = 8'h1D;
  localparam logic [7:0] SC_BL        = 8'h1C;
  localparam logic [7:0] SC_BR        = 8'h1B;
  localparam logic [7:0] SC_TR        = 8'h23;
  localparam logic [7:0] SC_SPACE     = 8'h29;
  localparam logic [7:0] SC_ARR_UP    = 8'h75;
  localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARR_RIGHT = 8'h74;

  localparam logic [2:0] DIR_NONE = 3'b000;
  localparam logic [2:0] DIR_TL   = 3'b111;
  localparam logic [2:0] DIR_BL   = 3'b101;
  localparam logic [2:0] DIR_BR   = 3'b100;
  localparam logic [2:0] DIR_TR   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  // Returns {hit, dir} for the plain letter direction keys.
  function automatic logic [3:0] map_base(input logic [7:0] code);
    case (code)
      SC_TL:   map_base = {1'b1, DIR_TL};
      SC_BL:   map_base = {1'b1, DIR_BL};
      SC_BR:   map_base = {1'b1, DIR_BR};
      SC_TR:   map_base = {1'b1, DIR_TR};
      default: map_base = {1'b0, DIR_NONE};
    endcase
  endfunction

  // Returns {hit, dir} for the extended (E0-prefixed) arrow keys.
  function automatic logic [3:0] map_arrow(input logic [7:0] code);
    case (code)
      SC_ARR_UP:    map_arrow = {1'b1, DIR_TL};
      SC_ARR_LEFT:  map_arrow = {1'b1, DIR_BL};
      SC_ARR_DOWN:  map_arrow = {1'b1, DIR_BR};
      SC_ARR_RIGHT: map_arrow = {1'b1, DIR_TR};
      default:      map_arrow = {1'b0, DIR_NONE};
    endcase
  endfunction

endpackage

// File: rtl/move_cooldown_timer.sv
// Down-counter enforcing a minimum gap between move pulses; busy while nonzero.
module move_cooldown_timer #(
  parameter int MOVE_COOLDOWN = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic clock,
  input  logic clear,
  input  logic load,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MOVE_COOLDOWN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Load wins over the decrement; the count saturates at zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/keyboard_move_decoder.sv
// PS/2 scan-code decoder producing rate-limited move pulses and a space-key
// activate pulse. Define KBD_ARROW_KEYS_EN to also accept the arrow keys.
module keyboard_move_decoder
  import kbd_pkg::*;
#(
  parameter int MOVE_COOLDOWN = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       move,
  output logic [2:0] dir,
  output logic       activate,
  output logic       key_held,
  output logic [1:0] fsm_state
);

  kbd_state_t state, state_next;

  logic       make_en;
  logic       break_en;
  logic       ext;
  logic [3:0] dir_map;
  logic       space_hit;
  logic       busy;
  logic       repeat_hit;
  logic       accept_move;
  logic       release_key;
  logic       held_valid;
  logic [8:0] held_code;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    make_en    = 1'b0;
    break_en   = 1'b0;
    ext        = 1'b0;
    if (received_data_en) begin
      case (state)
        ST_IDLE: begin
          if (received_data == SC_EXT) begin
            state_next = ST_EXT;
          end else if (received_data == SC_BRK) begin
            state_next = ST_BRK;
          end else begin
            make_en = 1'b1;
          end
        end
        ST_EXT: begin
          if (received_data == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else begin
            make_en    = 1'b1;
            ext        = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          break_en   = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          break_en   = 1'b1;
          ext        = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dir_map = map_base(received_data);
    if (ext) begin
`ifdef KBD_ARROW_KEYS_EN
      dir_map = map_arrow(received_data);
`else
      dir_map = {1'b0, DIR_NONE};
`endif
    end
  end

  assign space_hit  = make_en && !ext && (received_data == SC_SPACE);
  assign repeat_hit = held_valid && (held_code == {ext, received_data});
  // The ~move term keeps pulses single-cycle even with a zero cooldown.
  assign accept_move = make_en && dir_map[3] && !busy && !repeat_hit && !move;
  assign release_key = break_en && repeat_hit;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      move       <= 1'b0;
      activate   <= 1'b0;
      dir        <= DIR_NONE;
      held_valid <= 1'b0;
      held_code  <= '0;
    end else begin
      move     <= accept_move;
      activate <= space_hit && !activate;
      if (accept_move) begin
        dir        <= dir_map[2:0];
        held_code  <= {ext, received_data};
        held_valid <= 1'b1;
      end else if (release_key) begin
        held_valid <= 1'b0;
      end
    end
  end

  move_cooldown_timer #(
    .MOVE_COOLDOWN(MOVE_COOLDOWN),
    .CNT_W        (CNT_W)
  ) u_cooldown (
    .clock(clock),
    .clear(!resetn),
    .load (accept_move),
    .busy (busy)
  );

  assign key_held  = held_valid;
  assign fsm_state = state;

endmodule

// File: tb/tb_keyboard_move_decoder.sv
// Directed bench for keyboard_move_decoder with a short cooldown of 8 cycles.
module tb_keyboard_move_decoder;
  import kbd_pkg::*;

  logic       clock;
  logic       resetn;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       move;
  logic [2:0] dir;
  logic       activate;
  logic       key_held;
  logic [1:0] fsm_state;

  int checks;
  int errors;
  int move_cnt;

  keyboard_move_decoder #(
    .MOVE_COOLDOWN(8),
    .CNT_W        (4)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .move            (move),
    .dir             (dir),
    .activate        (activate),
    .key_held        (key_held),
    .fsm_state       (fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (move) move_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clock);
    received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    move_cnt         = 0;
    resetn           = 1'b0;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);

    check("rst_move", 32'(move), 0);
    check("rst_activate", 32'(activate), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_key_held", 32'(key_held), 0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));

    // Test 1: first make code moves one cycle after the strobe
    send_byte(8'h1D);
    check("t1_move", 32'(move), 1);
    check("t1_dir", 32'(dir), 32'(3'b111));
    check("t1_key_held", 32'(key_held), 1);
    idle(1);
    check("t1_move_pulse", 32'(move), 0);

    // Test 2: typematic repeats never move, even once cooled down
    repeat (5) send_byte(8'h1D);
    idle(12);
    send_byte(8'h1D);
    check("t2_move_count", move_cnt, 1);
    send_byte(8'hF0);
    check("t2_state_brk", 32'(fsm_state), 32'(ST_BRK));
    send_byte(8'h1D);
    check("t2_key_released", 32'(key_held), 0);
    check("t2_no_move", 32'(move), 0);

    // Test 3: direction during cooldown dropped, accepted after expiry
    idle(12);
    send_byte(8'h1C);
    check("t3_move", 32'(move), 1);
    check("t3_dir", 32'(dir), 32'(3'b101));
    idle(1);
    send_byte(8'h23);
    check("t3_dropped_move", 32'(move), 0);
    check("t3_dropped_dir", 32'(dir), 32'(3'b101));
    idle(10);
    send_byte(8'h23);
    check("t3_move2", 32'(move), 1);
    check("t3_dir2", 32'(dir), 32'(3'b110));
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("t3_other_break", 32'(key_held), 1);
    send_byte(8'hF0);
    send_byte(8'h23);
    check("t3_release", 32'(key_held), 0);

    // Test 4: space key activate, independent of cooldown
    send_byte(8'h29);
    check("t4_activate", 32'(activate), 1);
    check("t4_no_move", 32'(move), 0);
    idle(1);
    check("t4_activate_pulse", 32'(activate), 0);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("t4_break_activate", 32'(activate), 0);
    check("t4_break_move", 32'(move), 0);

    // Test 5: extended arrow key
    idle(12);
    send_byte(8'hE0);
    check("t5_state_ext", 32'(fsm_state), 32'(ST_EXT));
    send_byte(8'h72);
`ifdef KBD_ARROW_KEYS_EN
    check("t5_arrow_move", 32'(move), 1);
    check("t5_arrow_dir", 32'(dir), 32'(3'b100));
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h72);
    check("t5_arrow_release", 32'(key_held), 0);
`else
    check("t5_arrow_move", 32'(move), 0);
    check("t5_arrow_held", 32'(key_held), 0);
    check("t5_arrow_dir", 32'(dir), 32'(3'b110));
`endif
    idle(12);
    send_byte(8'h1B);
    check("t5_plain_move", 32'(move), 1);
    check("t5_plain_dir", 32'(dir), 32'(3'b100));
    send_byte(8'hF0);
    send_byte(8'h1B);
    check("t5_plain_release", 32'(key_held), 0);

    // Test 6: reset after E0 discards the partial sequence
    idle(12);
    send_byte(8'hE0);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("t6_state", 32'(fsm_state), 32'(ST_IDLE));
    check("t6_dir_reset", 32'(dir), 0);
    send_byte(8'h1B);
    check("t6_move", 32'(move), 1);
    check("t6_dir", 32'(dir), 32'(3'b100));
    check("t6_key_held", 32'(key_held), 1);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
